// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan path.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // Active-low patterns, bit order g..a, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with frame snapshot,
// anti-ghosting guard and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter bit LZ_SUPPRESS  = 1'b0
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);

    logic [CW-1:0]     cnt_q, cnt_d;
    digit_idx_t        idx_q, idx_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic [3:0]        dp_snap_q, dp_snap_d;
    logic [3:0]        blank_snap_q, blank_snap_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              tick_q, tick_d;

    logic [3:0]        suppressed;
    logic [6:0]        seg_lit;
    logic              slot_end;

    hex_to_seg7 u_dec (
        .hex (snap_q[idx_q]),
        .seg (seg_lit)
    );

    // A digit is a leading zero when it and every digit left of it is zero.
    always_comb begin
        suppressed    = 4'b0000;
        suppressed[3] = LZ_SUPPRESS && (snap_q[3] == 4'h0);
        suppressed[2] = suppressed[3] && (snap_q[2] == 4'h0);
        suppressed[1] = suppressed[2] && (snap_q[1] == 4'h0);
    end

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        dp_snap_d    = dp_snap_q;
        blank_snap_d = blank_snap_q;
        tick_d       = 1'b0;
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        slot_end     = (cnt_q == CNT_MAX);

        if (enable) begin
            cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
            idx_d  = slot_end ? idx_q + 2'd1 : idx_q;
            tick_d = slot_end && (idx_q == 2'd3);
            if ((cnt_q == '0) && (idx_q == 2'd0)) begin
                snap_d       = {digit3, digit2, digit1, digit0};
                dp_snap_d    = dp_in;
                blank_snap_d = blank_mask;
            end
            if ((cnt_q >= GUARD) &&
                !blank_snap_q[idx_q] && !suppressed[idx_q]) begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = seg_lit;
                dp_d  = ~dp_snap_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap_q       <= '0;
            dp_snap_q    <= 4'h0;
            blank_snap_q <= 4'h0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            dp_snap_q    <= dp_snap_d;
            blank_snap_q <= blank_snap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule
